// File: rtl/operand_reduce_proc.sv
// -----------------------------------------------------------------------------
// operand_reduce_proc
//
// Purpose:
//   Holds NUM_IN operand registers of WIDTH bits that are loaded from a shared
//   bus. On a start pulse it folds them into one result with a selectable
//   operation (ADD / XOR / MAX / MIN), one operand per clock. The result is
//   offered on a valid/ready output.
//
// Optional build macro:
//   OPERAND_REDUCE_SATURATE_EN - ADD clamps to all-ones instead of wrapping.
//                                ovf is reported identically in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   din        in   [WIDTH-1:0]  shared operand load data
//   load       in   [NUM_IN-1:0] bit i loads din into operand i (IDLE only)
//   op         in   [1:0]  00 ADD, 01 XOR, 10 MAX (unsigned), 11 MIN (unsigned)
//   start      in   begin a reduction (IDLE only)
//   busy       out  FSM is not IDLE
//   out_data   out  [WIDTH-1:0] reduction result, held until the next result
//   out_valid  out  result is being offered (HOLD)
//   out_ready  in   consumer accepts the result (HOLD only)
//   ovf        out  ADD carry-out seen during the current/last reduction
//
// Handshake: out_valid is high for every cycle of HOLD. The transfer happens
// at the first rising edge where out_valid and out_ready are both high;
// out_valid drops after that edge. out_data/ovf never change while out_valid
// is high, and out_ready has no effect while out_valid is low.
// -----------------------------------------------------------------------------
module operand_reduce_proc #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din,
    input  logic [NUM_IN-1:0] load,
    input  logic [1:0]        op,
    input  logic              start,
    output logic              busy,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NUM_IN];
    logic [WIDTH-1:0]   regs_d [NUM_IN];
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         op_q, op_d;
    logic               run_ovf_q, run_ovf_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               ovf_q, ovf_d;

    // One reduction step: combine acc with the operand currently indexed.
    logic [WIDTH-1:0]   operand;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   step_val;
    logic               step_carry;

    always_comb begin
        operand    = regs_q[idx_q];
        sum        = {1'b0, acc_q} + {1'b0, operand};
        step_val   = acc_q;
        step_carry = 1'b0;
        case (op_q)
            2'b00: begin
                step_carry = sum[WIDTH];
`ifdef OPERAND_REDUCE_SATURATE_EN
                // Once clamped, acc is all-ones, so any further non-zero
                // addend carries again and keeps it clamped.
                step_val = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                step_val = sum[WIDTH-1:0];
`endif
            end
            2'b01:   step_val = acc_q ^ operand;
            2'b10:   step_val = (operand > acc_q) ? operand : acc_q;
            default: step_val = (operand < acc_q) ? operand : acc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        op_d       = op_q;
        run_ovf_d  = run_ovf_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (load[i]) regs_d[i] = din;
                end
                // acc seeds from the pre-load value of operand 0 even when a
                // load hits the same edge.
                if (start) begin
                    op_d      = op;
                    acc_d     = regs_q[0];
                    idx_d     = IDX_W'(1);
                    run_ovf_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                acc_d     = step_val;
                run_ovf_d = run_ovf_q | step_carry;
                if (idx_q == LAST_IDX) begin
                    out_data_d = step_val;
                    ovf_d      = run_ovf_q | step_carry;
                    state_d    = S_HOLD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < NUM_IN; i++) regs_q[i] <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            op_q       <= 2'b00;
            run_ovf_q  <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            run_ovf_q  <= run_ovf_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Status outputs decode registered state only.
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;

endmodule
